// File: rtl/bus_arbiter2_if.sv
// One memory-mapped bus port: request/payload from the master, rdata/done back from the slave.
// The arbiter takes two of these as slaves (m0, m1) and drives a third as master (s).
interface bus_arbiter2_if;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  wmask;
   logic        wen;
   logic        ren;
   logic [31:0] rdata;
   logic        done;

   modport master (output addr, wdata, wmask, wen, ren, input rdata, done);
   modport slave  (input addr, wdata, wmask, wen, ren, output rdata, done);
endinterface

// File: rtl/bus_arbiter2.sv
// Two-master round-robin arbiter for the shared data bus (m0 = CPU load/store, m1 = DMA/debug).
// Grant is locked for a whole transaction; a slave that never answers is closed by a timeout.
//
//   state    | meaning
//   ST_IDLE  | no owner, s_* request outputs held at 0, arbitration happens here
//   ST_BUSY0 | master 0 owns the bus until s_done or timeout
//   ST_BUSY1 | master 1 owns the bus until s_done or timeout
module bus_arbiter2 #(
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEADBEEF
) (
   input  logic            clk,
   input  logic            rst,
   bus_arbiter2_if.slave   m0,
   bus_arbiter2_if.slave   m1,
   bus_arbiter2_if.master  s,
   output logic [1:0]      grant,
   output logic            timeout_err
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_BUSY0 = 2'd1;
   localparam logic [1:0] ST_BUSY1 = 2'd2;

   localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
   localparam int CNT_W = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

   logic [1:0]       state_q, state_d;
   logic             last_grant_q, last_grant_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout_err_q, timeout_err_d;

   logic        req0, req1;
   logic        busy, own1;
   logic        expire;
   logic        done_v;
   logic [31:0] rdata_v;

   always_comb begin
      req0          = m0.wen | m0.ren;
      req1          = m1.wen | m1.ren;
      state_d       = state_q;
      last_grant_d  = last_grant_q;
      cnt_d         = cnt_q;
      timeout_err_d = timeout_err_q;

      own1    = (state_q == ST_BUSY1);
      busy    = (state_q == ST_BUSY0) || own1;
      // s_done landing on the final count wins over the timeout
      expire  = TO_EN && busy && (cnt_q == CNT_LAST) && !s.done;
      done_v  = busy && (s.done || expire);
      rdata_v = expire ? TIMEOUT_RDATA : s.rdata;

      s.addr   = '0;
      s.wdata  = '0;
      s.wmask  = '0;
      s.wen    = 1'b0;
      s.ren    = 1'b0;
      m0.done  = 1'b0;
      m0.rdata = '0;
      m1.done  = 1'b0;
      m1.rdata = '0;

      if (busy) begin
         s.addr  = own1 ? m1.addr  : m0.addr;
         s.wdata = own1 ? m1.wdata : m0.wdata;
         s.wmask = own1 ? m1.wmask : m0.wmask;
         s.wen   = (own1 ? m1.wen : m0.wen) & ~expire;
         s.ren   = (own1 ? m1.ren : m0.ren) & ~expire;
         if (own1) begin
            m1.done  = done_v;
            m1.rdata = rdata_v;
         end else begin
            m0.done  = done_v;
            m0.rdata = rdata_v;
         end
         if (done_v) begin
            state_d = ST_IDLE;
            if (expire) timeout_err_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end else begin
         state_d = ST_IDLE;
         if (req0 && (!req1 || last_grant_q)) begin
            state_d      = ST_BUSY0;
            last_grant_d = 1'b0;
            cnt_d        = '0;
         end else if (req1) begin
            state_d      = ST_BUSY1;
            last_grant_d = 1'b1;
            cnt_d        = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= ST_IDLE;
         last_grant_q  <= 1'b1;
         cnt_q         <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         last_grant_q  <= last_grant_d;
         cnt_q         <= cnt_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign grant       = {own1, (state_q == ST_BUSY0)};
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_bus_arbiter2.sv
// Scoreboard bench for bus_arbiter2: directed transactions push expected completions,
// a negedge monitor pops and compares whenever a master sees done.
module tb_bus_arbiter2;
   localparam int TO = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [1:0] grant;
   logic       timeout_err;

   bus_arbiter2_if m0_if ();
   bus_arbiter2_if m1_if ();
   bus_arbiter2_if s_if ();

   bus_arbiter2 #(.TIMEOUT_CYCLES(TO), .TIMEOUT_RDATA(32'hDEADBEEF)) dut (
      .clk(clk), .rst(rst), .m0(m0_if), .m1(m1_if), .s(s_if),
      .grant(grant), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          m;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wmask;
      logic        wen;
      logic        ren;
      logic [31:0] rdata;
      int          len;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   done_cnt[2] = '{0, 0};

   // slave model knobs
   int          slv_lat   = 0;
   bit          slv_never = 1'b0;
   logic [31:0] slv_rdata = '0;
   int          slv_cnt   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t mk(input int m, input logic [31:0] a, input logic [31:0] wd,
                               input logic [3:0] wm, input logic we, input logic re,
                               input logic [31:0] rd, input int len);
      exp_t e;
      e.m = m; e.addr = a; e.wdata = wd; e.wmask = wm;
      e.wen = we; e.ren = re; e.rdata = rd; e.len = len;
      return e;
   endfunction

   task automatic set_m(input int m, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] wm, input logic we, input logic re);
      if (m == 0) begin
         m0_if.addr = a; m0_if.wdata = wd; m0_if.wmask = wm; m0_if.wen = we; m0_if.ren = re;
      end else begin
         m1_if.addr = a; m1_if.wdata = wd; m1_if.wmask = wm; m1_if.wen = we; m1_if.ren = re;
      end
   endtask

   // hold a request until its done, then release one clock later (after the edge)
   task automatic drive(input int m, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] wm, input logic we, input logic re);
      bit seen;
      seen = 1'b0;
      set_m(m, a, wd, wm, we, re);
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         seen = (m == 0) ? m0_if.done : m1_if.done;
      end
      if (!seen) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drive_wait: m%0d got no done within 50 cycles", m);
      end
      @(posedge clk);
      #1;
      set_m(m, '0, '0, '0, 1'b0, 1'b0);
   endtask

   // slave: answers after slv_lat extra cycles of ownership, keyed off grant
   initial begin
      s_if.done  = 1'b0;
      s_if.rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         if (grant != 2'b00) begin
            slv_cnt++;
            s_if.done = !slv_never && (slv_cnt == slv_lat + 1);
         end else begin
            slv_cnt   = 0;
            s_if.done = 1'b0;
         end
         s_if.rdata = slv_rdata;
      end
   end

   // monitor
   int   busy_len = 0;
   int   mon_m;
   exp_t mon_e;
   initial begin
      forever begin
         @(negedge clk);
         if (grant != 2'b00) busy_len++;
         if (grant == 2'b00)
            chk("idle_s_req", s_if.addr | s_if.wdata | {28'b0, s_if.wmask} |
                              {30'b0, s_if.wen, s_if.ren}, 32'h0);
         if (m0_if.done || m1_if.done) begin
            mon_m = m1_if.done ? 1 : 0;
            chk("single_done", {31'b0, m0_if.done & m1_if.done}, 32'h0);
            if (sb_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_done: m%0d done, expected none", mon_m);
            end else begin
               mon_e = sb_q.pop_front();
               chk("done_master", mon_m, mon_e.m);
               chk("done_rdata", (mon_m == 1) ? m1_if.rdata : m0_if.rdata, mon_e.rdata);
               chk("other_rdata", (mon_m == 1) ? m0_if.rdata : m1_if.rdata, 32'h0);
               chk("s_addr", s_if.addr, mon_e.addr);
               chk("s_wdata", s_if.wdata, mon_e.wdata);
               chk("s_wmask", {28'b0, s_if.wmask}, {28'b0, mon_e.wmask});
               chk("s_wen_ren", {30'b0, s_if.wen, s_if.ren}, {30'b0, mon_e.wen, mon_e.ren});
               chk("busy_len", busy_len, mon_e.len);
            end
            done_cnt[mon_m]++;
         end
         if (grant == 2'b00) busy_len = 0;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   logic [1:0] pat[4] = '{2'b01, 2'b00, 2'b10, 2'b00};
   int d0, d1;

   initial begin
      set_m(0, '0, '0, '0, 1'b0, 1'b0);
      set_m(1, '0, '0, '0, 1'b0, 1'b0);
      #23;
      chk("rst_grant", {30'b0, grant}, 32'h0);
      chk("rst_err", {31'b0, timeout_err}, 32'h0);
      chk("rst_m0_done", {31'b0, m0_if.done}, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;

      // post-reset tie: m0 first, then m1, masks untouched
      slv_lat = 0; slv_rdata = 32'h0BAD0BAD;
      sb_q.push_back(mk(0, 32'h200, 32'hAAAA5555, 4'b1111, 1'b1, 1'b0, 32'h0BAD0BAD, 1));
      sb_q.push_back(mk(1, 32'h300, 32'h000000FF, 4'b0001, 1'b1, 1'b0, 32'h0BAD0BAD, 1));
      fork
         drive(0, 32'h200, 32'hAAAA5555, 4'b1111, 1'b1, 1'b0);
         drive(1, 32'h300, 32'h000000FF, 4'b0001, 1'b1, 1'b0);
      join
      @(posedge clk); #1;

      // continuous contention: 6 transactions, strict alternation
      slv_lat = 0; slv_rdata = 32'hC0DEC0DE;
      for (int i = 0; i < 3; i++) begin
         sb_q.push_back(mk(0, 32'h400 + 4 * i, 32'h0, 4'h0, 1'b0, 1'b1, 32'hC0DEC0DE, 1));
         sb_q.push_back(mk(1, 32'h500 + 4 * i, 32'h0, 4'h0, 1'b0, 1'b1, 32'hC0DEC0DE, 1));
      end
      d0 = done_cnt[0]; d1 = done_cnt[1];
      fork
         for (int i = 0; i < 3; i++) drive(0, 32'h400 + 4 * i, 32'h0, 4'h0, 1'b0, 1'b1);
         for (int j = 0; j < 3; j++) drive(1, 32'h500 + 4 * j, 32'h0, 4'h0, 1'b0, 1'b1);
         begin
            @(negedge clk);
            chk("cont_grant_0", {30'b0, grant}, 32'h0);
            for (int k = 1; k < 13; k++) begin
               @(negedge clk);
               chk("cont_grant_seq", {30'b0, grant}, {30'b0, pat[(k - 1) % 4]});
            end
         end
      join
      chk("cont_m0_dones", done_cnt[0] - d0, 3);
      chk("cont_m1_dones", done_cnt[1] - d1, 3);
      @(posedge clk); #1;

      // single read on m0, slave answers 2 cycles after seeing s_ren
      slv_lat = 2; slv_rdata = 32'h12345678;
      sb_q.push_back(mk(0, 32'h100, 32'h0, 4'h0, 1'b0, 1'b1, 32'h12345678, 3));
      fork
         drive(0, 32'h100, 32'h0, 4'h0, 1'b0, 1'b1);
         begin
            @(negedge clk);
            chk("rd_sren_c0", {31'b0, s_if.ren}, 32'h0);
            @(negedge clk);
            chk("rd_sren_c1", {31'b0, s_if.ren}, 32'h1);
            chk("rd_grant_c1", {30'b0, grant}, 32'h1);
         end
      join
      @(negedge clk);
      chk("rd_grant_after", {30'b0, grant}, 32'h0);
      @(posedge clk); #1;

      // s_done on the final count: normal completion, no error
      slv_lat = 3; slv_rdata = 32'h600DF00D;
      sb_q.push_back(mk(1, 32'h700, 32'h0, 4'h0, 1'b0, 1'b1, 32'h600DF00D, 4));
      drive(1, 32'h700, 32'h0, 4'h0, 1'b0, 1'b1);
      chk("final_cnt_err", {31'b0, timeout_err}, 32'h0);
      @(posedge clk); #1;

      // timeout: slave silent, forced completion in the 4th busy cycle
      slv_never = 1'b1; slv_rdata = 32'h11111111;
      sb_q.push_back(mk(1, 32'h800, 32'h0, 4'h0, 1'b0, 1'b0, 32'hDEADBEEF, TO));
      drive(1, 32'h800, 32'h0, 4'h0, 1'b0, 1'b1);
      chk("to_err_set", {31'b0, timeout_err}, 32'h1);
      repeat (3) @(negedge clk);
      chk("to_err_sticky", {31'b0, timeout_err}, 32'h1);
      @(posedge clk); #1;
      slv_never = 1'b0; slv_lat = 0; slv_rdata = 32'h22222222;
      sb_q.push_back(mk(0, 32'h900, 32'h13579BDF, 4'b0110, 1'b1, 1'b0, 32'h22222222, 1));
      drive(0, 32'h900, 32'h13579BDF, 4'b0110, 1'b1, 1'b0);
      chk("to_err_after_ok", {31'b0, timeout_err}, 32'h1);
      @(posedge clk); #1;

      // reset mid-transaction while s_done is high in BUSY0
      slv_lat = 1; slv_rdata = 32'h33333333;
      set_m(0, 32'hA00, 32'h0, 4'h0, 1'b0, 1'b1);
      @(posedge clk);
      @(posedge clk);
      #2;
      chk("mid_pre_grant", {30'b0, grant}, 32'h1);
      chk("mid_pre_done", {31'b0, m0_if.done}, 32'h1);
      rst = 1'b0;
      #1;
      chk("mid_grant", {30'b0, grant}, 32'h0);
      chk("mid_s_wen_ren", {30'b0, s_if.wen, s_if.ren}, 32'h0);
      chk("mid_m0_done", {31'b0, m0_if.done}, 32'h0);
      chk("mid_err", {31'b0, timeout_err}, 32'h0);
      set_m(0, '0, '0, '0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;

      // tie after reset release goes to m0
      slv_lat = 0; slv_rdata = 32'h44444444;
      sb_q.push_back(mk(0, 32'hB00, 32'h0, 4'h0, 1'b0, 1'b1, 32'h44444444, 1));
      sb_q.push_back(mk(1, 32'hC00, 32'h0, 4'h0, 1'b0, 1'b1, 32'h44444444, 1));
      fork
         drive(0, 32'hB00, 32'h0, 4'h0, 1'b0, 1'b1);
         drive(1, 32'hC00, 32'h0, 4'h0, 1'b0, 1'b1);
      join

      repeat (3) @(negedge clk);
      chk("sb_empty", sb_q.size(), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bus_arbiter2.md
# bus_arbiter2

Two-master, round-robin arbiter sharing the single memory-mapped data bus (`addr/wdata/wmask/wen/ren/rdata/done`) between the pipelined CPU's load/store port (master 0) and a second requester such as a DMA or debug loader (master 1). It sits between the CPU core and the peripheral/RAM interconnect. It locks the grant for the length of a transaction, returns `done`/`rdata` only to the owner, and closes any transaction the slave never acknowledges with a timeout error.

## Interface
- `TIMEOUT_CYCLES`, default 256: number of BUSY cycles without `s_done` before a forced completion; 0 disables the timeout.
- `TIMEOUT_RDATA`, default 32'hDEADBEEF: read data returned on a timed-out transaction.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `m0_addr`, `m0_wdata` input 32 each: master 0 (CPU) address and write data.
- `m0_wmask` input 4: master 0 byte write mask.
- `m0_wen`, `m0_ren` input 1 each: master 0 write and read requests, held at level until `m0_done`.
- `m0_rdata` output 32; `m0_done` output 1: master 0 read data and completion.
- `m1_addr`, `m1_wdata`, `m1_wmask`, `m1_wen`, `m1_ren`, `m1_rdata`, `m1_done`: master 1, same widths and meanings.
- `s_addr`, `s_wdata` output 32; `s_wmask` output 4; `s_wen`, `s_ren` output 1: slave-side request.
- `s_rdata` input 32; `s_done` input 1: slave response (may be combinational from the request).
- `grant` output 2: one-hot current owner; 2'b00 when IDLE.
- `timeout_err` output 1: sticky timeout flag.

## Operation
- Request from master m: `req_m = m_wen | m_ren`. Masters hold the request and all payload stable until they see their `done`.
- State machine: IDLE, BUSY0, BUSY1.
- IDLE:
  - All `s_*` request outputs are 0. `grant` is 0.
  - If exactly one `req_m` is high, go to BUSYm.
  - If both are high, grant the master that is not `last_grant`. `last_grant` updates on entry to BUSY.
- BUSYm:
  - `s_addr`, `s_wdata`, `s_wmask`, `s_wen`, `s_ren` pass combinationally from master m. `wen` and `ren` are forwarded as-is.
  - `m_done = s_done` and `m_rdata = s_rdata`.
  - The other master sees `done=0` and `rdata=0`.
  - On `s_done`, go to IDLE.
- If the owner drops its request while BUSY, the arbiter keeps the grant and still waits for `s_done` or the timeout. The completion is not suppressed. Its request outputs follow the live, now-zero, master signals.
- Timeout counter:
  - Width `$clog2(TIMEOUT_CYCLES+1)`. Cleared on entry to BUSY. Increments each BUSY cycle without `s_done`.
  - When count == TIMEOUT_CYCLES-1 and `s_done`=0: force `m_done=1`, set `m_rdata=TIMEOUT_RDATA`, drive `s_wen=s_ren=0` that cycle, set `timeout_err`, and go to IDLE.
  - `s_done` in the same cycle wins. It is a normal completion with no error.
- `timeout_err` is cleared only by reset.
- Reset (asynchronous, at any time, including mid-transaction):
  - State IDLE, `last_grant`=1 so master 0 wins the first tie, counter 0, `timeout_err` 0.
  - All outputs 0 immediately, without waiting for a clock edge.

## Timing
- Arbitration latency is 1 cycle. A request first seen in IDLE at edge N appears on `s_*` in cycle N+1.
- Completion is same-cycle. `m_done` and `m_rdata` equal `s_done` and `s_rdata` in the cycle `s_done` is high. The state is IDLE from the next edge.
- One IDLE cycle separates consecutive transactions. Minimum transaction period is 2 cycles with a zero-wait slave.
- With both masters requesting continuously, grants strictly alternate 0,1,0,1.
- There is no combinational path from `m*_wen/ren` to `grant`. `grant` is a pure state decode.
- A timed-out transaction completes exactly TIMEOUT_CYCLES cycles after BUSY entry.

## Test plan
- **Single read, master 0.** Stimulus: `m0_ren`=1, `m0_addr`=0x100; slave asserts `s_done` 2 cycles after seeing `s_ren`, with `s_rdata`=0x12345678. Required: `s_ren` goes high 1 cycle after the request; `m0_done`=1 with `m0_rdata`=0x12345678 in that cycle; `m1_done` stays 0; `grant` is 01 for 3 cycles and 00 otherwise.
- **Post-reset tie.** Stimulus: both masters write simultaneously (m0 0xAAAA5555 mask 4'b1111; m1 0x000000FF mask 4'b0001). Required: master 0 is served first and master 1 next. Slave sees m0's data then m1's, with the masks unchanged.
- **Continuous contention.** Stimulus: both masters request for 6 transactions against a zero-wait slave. Required: `grant` sequence 01,00,10,00,01,00,…; each master receives 3 `done` pulses.
- **Timeout.** Stimulus: TIMEOUT_CYCLES=4, slave never asserts `s_done`, `m1_ren`=1. Required: `m1_done`=1 with `m1_rdata`=0xDEADBEEF in the 4th BUSY cycle; `s_ren`=0 in that cycle; `timeout_err` goes to 1 and stays 1. A later normal transaction completes and leaves `timeout_err` at 1.
- **Done on the final count.** Stimulus: TIMEOUT_CYCLES=4 and `s_done` arrives in the 4th BUSY cycle. Required: normal completion with the slave's `rdata`; `timeout_err` stays 0.
- **Reset mid-transaction.** Stimulus: `rst` pulled low while in BUSY0. Required: `grant`, `s_wen`, `s_ren` and `m0_done` are 0 before the next clock edge. After release, a tie grants master 0.
